regfile_sb_bypass: RTL and testbench
====================================

Name: regfile_sb_bypass

Overview:
Parametrised multi-port general-purpose register file for the CPU datapath. It has two write ports (ALU/writeback and load return) and two combinational read ports, with same-cycle write-to-read bypass. It also keeps a per-register pending-write scoreboard so the issue stage can detect RAW hazards.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; register count NREG = 2**ADDR_W
ZERO_R0, 1, 1 = register 0 reads as zero and ignores writes and reservations; 0 = register 0 is ordinary

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
wr_en_a  input  1  write port A enable (writeback)
wr_addr_a  input  ADDR_W  write port A address
wr_data_a  input  DATA_W  write port A data
wr_en_b  input  1  write port B enable (load return)
wr_addr_b  input  ADDR_W  write port B address
wr_data_b  input  DATA_W  write port B data
rd_addr_1  input  ADDR_W  read port 1 address
rd_data_1  output  DATA_W  read port 1 data (combinational)
rd_busy_1  output  1  scoreboard pending bit for rd_addr_1 (combinational)
rd_addr_2  input  ADDR_W  read port 2 address
rd_data_2  output  DATA_W  read port 2 data (combinational)
rd_busy_2  output  1  scoreboard pending bit for rd_addr_2 (combinational)
rsv_en  input  1  reserve destination register (issue stage)
rsv_addr  input  ADDR_W  register to reserve
pend_cnt  output  ADDR_W+1  number of registers currently pending (registered)
wr_conflict  output  1  one-cycle pulse: both write ports hit the same address (registered)
rsv_err  output  1  one-cycle pulse: reservation of an already-pending register (registered)

Behaviour:
- Reset (async, rst=1): all NREG registers = 0; all pending bits = 0; pend_cnt = 0; wr_conflict = 0; rsv_err = 0. Read outputs then reflect zeros and busy = 0. Reset mid-operation discards all in-flight writes and reservations immediately.
- Writes occur on the rising clk edge; the new value is visible in the array from the next cycle.
- Both ports enabled to the same address: port B data is written. wr_conflict = 1 for exactly the following cycle.
- Read data is combinational with bypass, in this priority order:
  - ZERO_R0=1 and addr==0 -> 0.
  - Else wr_en_b && wr_addr_b==addr -> wr_data_b.
  - Else wr_en_a && wr_addr_a==addr -> wr_data_a.
  - Else the array contents.
- Both read ports are independent and may read the same address.
- Scoreboard, one pending bit per register, updated per edge:
  - Set by rsv_en at rsv_addr.
  - Cleared by any enabled write (A or B) to that address.
  - Same edge, same address, reserve and write: the write lands in the array but the pending bit ends at 1 (the new reservation wins).
  - Write to a non-pending register: data is written; the bit stays 0.
- rd_busy_n = pending[rd_addr_n], with no bypass: a register being cleared this cycle still shows busy until the edge. With ZERO_R0=1, rd_busy_n = 0 for address 0.
- rsv_en to an address whose pending bit is already 1: the bit stays 1, and rsv_err = 1 for the next cycle.
- ZERO_R0=1: writes and reservations to register 0 are dropped. No wr_conflict or rsv_err is raised for address 0.
- pend_cnt is the registered population count of the pending bits after the edge. Range 0..NREG, no wrap. With ZERO_R0=1 the maximum is NREG-1.
- Enables deasserted: address and data inputs are don't-care. X on a disabled port must not corrupt state.

Test Plan:
1. Reset, then read all addresses -> rd_data = 0, rd_busy = 0, pend_cnt = 0. Assert rst mid-traffic -> same within the reset cycle.
2. Write A r5=0x1234 with rd_addr_1=5 in the same cycle -> rd_data_1 = 0x1234 (bypass) that cycle and 0x1234 afterwards. Write r0=0xFFFF -> read r0 = 0.
3. Same cycle A r3=0xAAAA and B r3=0x5555 -> rd_data = 0x5555 (bypass); next cycle r3 = 0x5555 and wr_conflict = 1 for one cycle only.
4. Reserve r7 -> next cycle rd_busy for r7 = 1 and pend_cnt = 1. Reserve r7 again -> rsv_err pulse, pend_cnt stays 1. Write B r7=0x00FF -> busy = 0, pend_cnt = 0.
5. Reserve r9 while port A writes r9=0x0042 on the same edge -> r9 = 0x0042, busy = 1, pend_cnt = 1.
6. Reserve r1..r15 on consecutive cycles -> pend_cnt reaches 15 (ZERO_R0=1). Repeat with ZERO_R0=0, reserving r0..r15 -> pend_cnt = 16. Write each back -> pend_cnt counts down to 0.

Source files
------------

// File: rtl/regfile_sb_bypass_if.sv
// Port bundle for the bypassed register file: two write ports, two read ports,
// reservation input and scoreboard status.
interface regfile_sb_bypass_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              wr_en_a;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [DATA_W-1:0] wr_data_a;
  logic              wr_en_b;
  logic [ADDR_W-1:0] wr_addr_b;
  logic [DATA_W-1:0] wr_data_b;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [DATA_W-1:0] rd_data_1;
  logic              rd_busy_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic [DATA_W-1:0] rd_data_2;
  logic              rd_busy_2;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W:0]   pend_cnt;
  logic              wr_conflict;
  logic              rsv_err;

  modport master (
    output wr_en_a, wr_addr_a, wr_data_a,
    output wr_en_b, wr_addr_b, wr_data_b,
    output rd_addr_1, rd_addr_2, rsv_en, rsv_addr,
    input  rd_data_1, rd_busy_1, rd_data_2, rd_busy_2,
    input  pend_cnt, wr_conflict, rsv_err
  );

  modport slave (
    input  wr_en_a, wr_addr_a, wr_data_a,
    input  wr_en_b, wr_addr_b, wr_data_b,
    input  rd_addr_1, rd_addr_2, rsv_en, rsv_addr,
    output rd_data_1, rd_busy_1, rd_data_2, rd_busy_2,
    output pend_cnt, wr_conflict, rsv_err
  );
endinterface

// File: rtl/regfile_sb_bypass.sv
// Two-write / two-read register file with same-cycle write bypass and a
// per-register pending-write scoreboard for RAW hazard detection.
module regfile_sb_bypass #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  regfile_sb_bypass_if.slave  bus
);

  localparam int unsigned NREG  = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [NREG-1:0]   pend_q;
  logic [NREG-1:0]   pend_d;
  logic [CNT_W-1:0]  pend_cnt_q;
  logic [CNT_W-1:0]  pend_cnt_d;
  logic              wr_conflict_q;
  logic              rsv_err_q;
  logic              we_a;
  logic              we_b;
  logic              rsv_ok;

  // Register 0 is hardwired when ZERO_R0 is set.
  function automatic logic is_r0(input logic [ADDR_W-1:0] addr);
    return ZERO_R0 && (addr == '0);
  endfunction

  // Qualified enables: disabled ports short-circuit so X addresses cannot leak in.
  assign we_a   = bus.wr_en_a && !is_r0(bus.wr_addr_a);
  assign we_b   = bus.wr_en_b && !is_r0(bus.wr_addr_b);
  assign rsv_ok = bus.rsv_en  && !is_r0(bus.rsv_addr);

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (is_r0(addr))                      return '0;
    else if (we_b && bus.wr_addr_b == addr) return bus.wr_data_b;
    else if (we_a && bus.wr_addr_a == addr) return bus.wr_data_a;
    else                                  return mem_q[addr];
  endfunction

  assign bus.rd_data_1 = read_port(bus.rd_addr_1);
  assign bus.rd_data_2 = read_port(bus.rd_addr_2);
  assign bus.rd_busy_1 = is_r0(bus.rd_addr_1) ? 1'b0 : pend_q[bus.rd_addr_1];
  assign bus.rd_busy_2 = is_r0(bus.rd_addr_2) ? 1'b0 : pend_q[bus.rd_addr_2];

  // Writes clear pending bits, a same-edge reservation re-sets them.
  always_comb begin
    pend_d     = pend_q;
    pend_cnt_d = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (we_a && bus.wr_addr_a == ADDR_W'(i)) pend_d[i] = 1'b0;
      if (we_b && bus.wr_addr_b == ADDR_W'(i)) pend_d[i] = 1'b0;
      if (rsv_ok && bus.rsv_addr == ADDR_W'(i)) pend_d[i] = 1'b1;
      pend_cnt_d = pend_cnt_d + CNT_W'(pend_d[i]);
    end
  end

  // Array update; port B is written last so it wins an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      if (we_a) mem_q[bus.wr_addr_a] <= bus.wr_data_a;
      if (we_b) mem_q[bus.wr_addr_b] <= bus.wr_data_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q        <= '0;
      pend_cnt_q    <= '0;
      wr_conflict_q <= 1'b0;
      rsv_err_q     <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      pend_cnt_q    <= pend_cnt_d;
      wr_conflict_q <= we_a && we_b && (bus.wr_addr_a == bus.wr_addr_b);
      rsv_err_q     <= rsv_ok && pend_q[bus.rsv_addr];
    end
  end

  assign bus.pend_cnt    = pend_cnt_q;
  assign bus.wr_conflict = wr_conflict_q;
  assign bus.rsv_err     = rsv_err_q;

endmodule

// File: tb/tb_regfile_sb_bypass.sv
// Bench for regfile_sb_bypass: one instance with ZERO_R0=1 and one with ZERO_R0=0,
// driven identically and compared against a per-register behavioural model.
module tb_regfile_sb_bypass;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_bypass_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
  regfile_sb_bypass_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();

  regfile_sb_bypass #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  regfile_sb_bypass #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b0)) u1 (.clk(clk), .rst(rst), .bus(b1));

  int n_chk = 0;
  int n_fail = 0;

  // Model state, index 0 = ZERO_R0=1 instance, index 1 = ordinary r0.
  logic [DW-1:0] m_mem  [2][NR];
  bit            m_pend [2][NR];
  int            m_cnt  [2];
  bit            m_conf [2];
  bit            m_rerr [2];

  bit            ea, eb, re;
  logic [AW-1:0] aa, ab, ra, r1, r2;
  logic [DW-1:0] da, db;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit dropped(input int k, input logic [AW-1:0] a);
    return (k == 0) && (a == 0);
  endfunction

  function automatic logic [DW-1:0] m_read(input int k, input logic [AW-1:0] a);
    if (dropped(k, a))      return '0;
    if (eb && ab == a)      return db;
    if (ea && aa == a)      return da;
    return m_mem[k][a];
  endfunction

  function automatic bit m_busy(input int k, input logic [AW-1:0] a);
    return dropped(k, a) ? 1'b0 : m_pend[k][a];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) begin
        m_mem[k][i]  = '0;
        m_pend[k][i] = 1'b0;
      end
      m_cnt[k]  = 0;
      m_conf[k] = 1'b0;
      m_rerr[k] = 1'b0;
    end
  endtask

  task automatic m_edge();
    for (int k = 0; k < 2; k++) begin
      bit wa, wb, rv;
      wa = ea && !dropped(k, aa);
      wb = eb && !dropped(k, ab);
      rv = re && !dropped(k, ra);
      m_conf[k] = wa && wb && (aa == ab);
      m_rerr[k] = rv && m_pend[k][ra];
      if (wa) begin m_mem[k][aa] = da; m_pend[k][aa] = 1'b0; end
      if (wb) begin m_mem[k][ab] = db; m_pend[k][ab] = 1'b0; end
      if (rv) m_pend[k][ra] = 1'b1;
      m_cnt[k] = 0;
      for (int i = 0; i < NR; i++) m_cnt[k] += int'(m_pend[k][i]);
    end
  endtask

  // Disabled ports are driven with X to prove they cannot disturb state.
  task automatic apply();
    b0.wr_en_a   = ea;               b1.wr_en_a   = ea;
    b0.wr_addr_a = ea ? aa : 'x;     b1.wr_addr_a = ea ? aa : 'x;
    b0.wr_data_a = ea ? da : 'x;     b1.wr_data_a = ea ? da : 'x;
    b0.wr_en_b   = eb;               b1.wr_en_b   = eb;
    b0.wr_addr_b = eb ? ab : 'x;     b1.wr_addr_b = eb ? ab : 'x;
    b0.wr_data_b = eb ? db : 'x;     b1.wr_data_b = eb ? db : 'x;
    b0.rsv_en    = re;               b1.rsv_en    = re;
    b0.rsv_addr  = re ? ra : 'x;     b1.rsv_addr  = re ? ra : 'x;
    b0.rd_addr_1 = r1;               b1.rd_addr_1 = r1;
    b0.rd_addr_2 = r2;               b1.rd_addr_2 = r2;
  endtask

  task automatic check_comb();
    check("z1_rd_data_1", 32'(b0.rd_data_1), 32'(m_read(0, r1)));
    check("z1_rd_data_2", 32'(b0.rd_data_2), 32'(m_read(0, r2)));
    check("z1_rd_busy_1", 32'(b0.rd_busy_1), 32'(m_busy(0, r1)));
    check("z1_rd_busy_2", 32'(b0.rd_busy_2), 32'(m_busy(0, r2)));
    check("z0_rd_data_1", 32'(b1.rd_data_1), 32'(m_read(1, r1)));
    check("z0_rd_data_2", 32'(b1.rd_data_2), 32'(m_read(1, r2)));
    check("z0_rd_busy_1", 32'(b1.rd_busy_1), 32'(m_busy(1, r1)));
    check("z0_rd_busy_2", 32'(b1.rd_busy_2), 32'(m_busy(1, r2)));
  endtask

  task automatic check_reg();
    check("z1_pend_cnt",    32'(b0.pend_cnt),    32'(m_cnt[0]));
    check("z1_wr_conflict", 32'(b0.wr_conflict), 32'(m_conf[0]));
    check("z1_rsv_err",     32'(b0.rsv_err),     32'(m_rerr[0]));
    check("z0_pend_cnt",    32'(b1.pend_cnt),    32'(m_cnt[1]));
    check("z0_wr_conflict", 32'(b1.wr_conflict), 32'(m_conf[1]));
    check("z0_rsv_err",     32'(b1.rsv_err),     32'(m_rerr[1]));
  endtask

  // One clock: drive, check bypass reads before the edge, then registered outputs after it.
  task automatic step(input bit i_ea, input logic [AW-1:0] i_aa, input logic [DW-1:0] i_da,
                      input bit i_eb, input logic [AW-1:0] i_ab, input logic [DW-1:0] i_db,
                      input bit i_re, input logic [AW-1:0] i_ra,
                      input logic [AW-1:0] i_r1, input logic [AW-1:0] i_r2);
    ea = i_ea; aa = i_aa; da = i_da;
    eb = i_eb; ab = i_ab; db = i_db;
    re = i_re; ra = i_ra; r1 = i_r1; r2 = i_r2;
    apply();
    #1;
    check_comb();
    m_edge();
    @(posedge clk);
    #1;
    check_reg();
  endtask

  task automatic idle(input logic [AW-1:0] i_r1, input logic [AW-1:0] i_r2);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, i_r1, i_r2);
  endtask

  // Look at the array without clocking; all enables low.
  task automatic peek(input logic [AW-1:0] i_r1, input logic [AW-1:0] i_r2);
    ea = 1'b0; eb = 1'b0; re = 1'b0; r1 = i_r1; r2 = i_r2;
    apply();
    #1;
    check_comb();
  endtask

  task automatic release_reset();
    ea = 1'b0; eb = 1'b0; re = 1'b0;
    apply();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_reset();
    ea = 1'b0; eb = 1'b0; re = 1'b0; aa = '0; ab = '0; ra = '0; da = '0; db = '0;
    r1 = '0; r2 = '0;
    rst = 1'b1;
    apply();
    #2;
    // Reset state across every address.
    for (int a = 0; a < NR; a++) peek(AW'(a), AW'(NR - 1 - a));
    check_reg();
    release_reset();

    // Bypass on write, then persistence; r0 hardwired only in the ZERO_R0 instance.
    step(1'b1, 4'd5, 16'h1234, 1'b0, '0, '0, 1'b0, '0, 4'd5, 4'd5);
    peek(4'd5, 4'd0);
    check("r5_after_write", 32'(b0.rd_data_1), 32'h1234);
    step(1'b1, 4'd0, 16'hFFFF, 1'b0, '0, '0, 1'b0, '0, 4'd0, 4'd0);
    peek(4'd0, 4'd5);
    check("z1_r0_reads_zero", 32'(b0.rd_data_1), 32'h0);
    check("z0_r0_holds_data", 32'(b1.rd_data_1), 32'hFFFF);

    // Same-address collision: B wins, conflict pulse lasts one cycle.
    step(1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd3, 16'h5555, 1'b0, '0, 4'd3, 4'd3);
    check("conflict_pulse", 32'(b0.wr_conflict), 32'h1);
    idle(4'd3, 4'd3);
    check("conflict_cleared", 32'(b0.wr_conflict), 32'h0);
    check("r3_port_b_wins", 32'(b0.rd_data_1), 32'h5555);
    // Collision at r0 raises no conflict in the ZERO_R0 instance.
    step(1'b1, 4'd0, 16'h1111, 1'b1, 4'd0, 16'h2222, 1'b0, '0, 4'd0, 4'd0);
    check("z1_no_r0_conflict", 32'(b0.wr_conflict), 32'h0);
    check("z0_r0_conflict", 32'(b1.wr_conflict), 32'h1);

    // Reserve, double reserve, and write-back release.
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd7, 4'd7, 4'd7);
    check("r7_pend_cnt_1", 32'(b0.pend_cnt), 32'd1);
    check("r7_busy", 32'(b0.rd_busy_1), 32'h1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd7, 4'd7, 4'd7);
    check("r7_rsv_err", 32'(b0.rsv_err), 32'h1);
    check("r7_pend_cnt_still_1", 32'(b0.pend_cnt), 32'd1);
    step(1'b0, '0, '0, 1'b1, 4'd7, 16'h00FF, 1'b0, '0, 4'd7, 4'd7);
    check("r7_released", 32'(b0.pend_cnt), 32'd0);
    check("r7_rsv_err_gone", 32'(b0.rsv_err), 32'h0);

    // Reservation beats a same-edge write to the same register.
    step(1'b1, 4'd9, 16'h0042, 1'b0, '0, '0, 1'b1, 4'd9, 4'd9, 4'd9);
    peek(4'd9, 4'd9);
    check("r9_data", 32'(b0.rd_data_1), 32'h0042);
    check("r9_busy", 32'(b0.rd_busy_1), 32'h1);
    step(1'b0, '0, '0, 1'b1, 4'd9, 16'h0043, 1'b0, '0, 4'd9, 4'd8);

    // Fill the scoreboard, then drain it.
    for (int i = 0; i < NR; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, AW'(i), AW'(i), 4'd0);
    check("z1_full_cnt", 32'(b0.pend_cnt), 32'd15);
    check("z0_full_cnt", 32'(b1.pend_cnt), 32'd16);
    for (int i = 0; i < NR; i++) step(1'b1, AW'(i), DW'(16'h0100 + i), 1'b0, '0, '0, 1'b0, '0, AW'(i), AW'(NR - 1 - i));
    check("z1_drained", 32'(b0.pend_cnt), 32'd0);
    check("z0_drained", 32'(b1.pend_cnt), 32'd0);

    // Random traffic with occasional asynchronous reset mid-cycle.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #1;
        m_reset();
        check_comb();
        check_reg();
        release_reset();
      end else begin
        step(1'($urandom_range(0, 2) == 0), AW'($urandom), DW'($urandom),
             1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), DW'($urandom),
             1'($urandom_range(0, 1)), AW'($urandom),
             AW'($urandom), AW'($urandom_range(0, 7)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
